instr_stream_encoder: RTL and testbench

Sequential instruction encoder and program loader. It accepts a stream of symbolic operations (operation enum, register indices, immediate) over a valid/ready handshake and packs each into a 32-bit instruction word in the core's custom ISA encoding. It writes each word into instruction memory at consecutive addresses. It is the inverse of the main control unit's decode path and is used for boot-time program loading and by test benches.

---
 rtl/instr_stream_encoder_pkg.sv | 90 +++++++++
 rtl/instr_stream_encoder_field.sv | 38 +++
 rtl/instr_stream_encoder.sv | 156 +++++++++++++++
 tb/tb_instr_stream_encoder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_stream_encoder_pkg.sv
// Shared encoding constants, operation/state enums and instruction layout helpers
// for the instruction stream encoder.
package instr_stream_encoder_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_XOR  = 4'd4,
        OP_SRL  = 4'd5,
        OP_OR   = 4'd6,
        OP_AND  = 4'd7,
        OP_BEQ  = 4'd8,
        OP_BLT  = 4'd9,
        OP_SW   = 4'd10,
        OP_LW   = 4'd11,
        OP_LUI  = 4'd12,
        OP_ADDI = 4'd13,
        OP_ORI  = 4'd14,
        OP_XORI = 4'd15
    } op_e;

    // The PAD state only exists when halt padding is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
`ifdef HALT_PAD_EN
        ST_PAD  = 3'd2,
`endif
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    localparam logic [6:0] OPC_RTYPE  = 7'b1110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1101011;
    localparam logic [6:0] OPC_STORE  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b1000011;
    localparam logic [6:0] OPC_LUI    = 7'b0110000;
    localparam logic [6:0] OPC_IALU   = 7'b0011111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BLT  = 3'b001;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_ORI  = 3'b001;
    localparam logic [2:0] F3_XORI = 3'b010;

    // BEQ x0,x0,0 -- a self-loop the core parks on once the program ends.
    localparam logic [31:0] HALT_WORD = 32'h0000_006B;

    function automatic logic [31:0] r_word(input logic [6:0] opc, input logic [2:0] f3,
                                           input logic alt, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2);
        return {1'b0, alt, 5'b00000, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] i_word(input logic [6:0] opc, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] s_word(input logic [6:0] opc, input logic [2:0] f3,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
    endfunction

    // ofs holds byte-offset bits [12:1]; bit 0 of a branch offset is always zero.
    function automatic logic [31:0] b_word(input logic [6:0] opc, input logic [2:0] f3,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [11:0] ofs);
        return {ofs[11], ofs[9:4], rs2, rs1, f3, ofs[3:0], ofs[10], opc};
    endfunction

    function automatic logic [31:0] u_word(input logic [6:0] opc, input logic [4:0] rd,
                                           input logic [19:0] imm);
        return {imm, rd, opc};
    endfunction

endpackage

// File: rtl/instr_stream_encoder_field.sv
// instr_field_encoder: purely combinational mapping of one symbolic operation
// onto its 32-bit instruction word.
module instr_field_encoder
    import instr_stream_encoder_pkg::*;
(
    input  op_e         op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [19:0] imm,
    output logic [31:0] word
);

    // Select the instruction format and function codes for the operation.
    always_comb begin
        word = 32'h0000_0000;
        case (op)
            OP_ADD:  word = r_word(OPC_RTYPE, F3_ADD, 1'b0, rd, rs1, rs2);
            OP_SUB:  word = r_word(OPC_RTYPE, F3_ADD, 1'b1, rd, rs1, rs2);
            OP_SLL:  word = r_word(OPC_RTYPE, F3_SLL, 1'b0, rd, rs1, rs2);
            OP_SLT:  word = r_word(OPC_RTYPE, F3_SLT, 1'b0, rd, rs1, rs2);
            OP_XOR:  word = r_word(OPC_RTYPE, F3_XOR, 1'b0, rd, rs1, rs2);
            OP_SRL:  word = r_word(OPC_RTYPE, F3_SRL, 1'b0, rd, rs1, rs2);
            OP_OR:   word = r_word(OPC_RTYPE, F3_OR,  1'b0, rd, rs1, rs2);
            OP_AND:  word = r_word(OPC_RTYPE, F3_AND, 1'b0, rd, rs1, rs2);
            OP_BEQ:  word = b_word(OPC_BRANCH, F3_BEQ, rs1, rs2, imm[12:1]);
            OP_BLT:  word = b_word(OPC_BRANCH, F3_BLT, rs1, rs2, imm[12:1]);
            OP_SW:   word = s_word(OPC_STORE, F3_SW, rs1, rs2, imm[11:0]);
            OP_LW:   word = i_word(OPC_LOAD, F3_LW, rd, rs1, imm[11:0]);
            OP_LUI:  word = u_word(OPC_LUI, rd, imm);
            OP_ADDI: word = i_word(OPC_IALU, F3_ADDI, rd, rs1, imm[11:0]);
            OP_ORI:  word = i_word(OPC_IALU, F3_ORI, rd, rs1, imm[11:0]);
            OP_XORI: word = i_word(OPC_IALU, F3_XORI, rd, rs1, imm[11:0]);
            default: word = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/instr_stream_encoder.sv
// Program loader: encodes a handshaked op stream and writes it to consecutive
// instruction-memory words. Define HALT_PAD_EN to append a halt word after the last op.
module instr_stream_encoder
    import instr_stream_encoder_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [19:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_r;
    logic              in_ready_r;
    logic              imem_we_r;
    logic [ADDR_W-1:0] imem_addr_r;
    logic [31:0]       imem_wdata_r;
    logic              busy_r;
    logic              done_r;
    logic              err_r;
    logic [ADDR_W:0]   count_r;

    logic [31:0]       enc_word_s;
    logic              accept_s;
    logic [ADDR_W:0]   count_inc_s;

    instr_field_encoder u_field_encoder (
        .op   (op_e'(in_op)),
        .rd   (in_rd),
        .rs1  (in_rs1),
        .rs2  (in_rs2),
        .imm  (in_imm),
        .word (enc_word_s)
    );

    assign accept_s    = in_valid && in_ready_r;
    assign count_inc_s = count_r + ONE;

    // Load FSM; the write strobe/address/data registers double as the one-entry pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            in_ready_r   <= 1'b0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= {ADDR_W{1'b0}};
            imem_wdata_r <= 32'h0000_0000;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            count_r      <= {(ADDR_W+1){1'b0}};
        end else begin
            imem_we_r <= 1'b0;
            done_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_LOAD;
                        count_r    <= {(ADDR_W+1){1'b0}};
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end else begin
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        imem_we_r    <= 1'b1;
                        imem_addr_r  <= count_r[ADDR_W-1:0];
                        imem_wdata_r <= enc_word_s;
                        count_r      <= count_inc_s;
                        if (in_last) begin
                            in_ready_r <= 1'b0;
`ifdef HALT_PAD_EN
                            if (count_inc_s < DEPTH) begin
                                state_r <= ST_PAD;
                            end else begin
                                state_r <= ST_DONE;
                            end
`else
                            state_r <= ST_DONE;
`endif
                        end else if (count_inc_s == DEPTH) begin
                            // Memory is full but the program has not ended.
                            state_r    <= ST_ERR;
                            err_r      <= 1'b1;
                            in_ready_r <= 1'b0;
                        end else begin
                            in_ready_r <= 1'b1;
                        end
                    end else begin
                        in_ready_r <= (count_r < DEPTH);
                    end
                end
`ifdef HALT_PAD_EN
                ST_PAD: begin
                    imem_we_r    <= 1'b1;
                    imem_addr_r  <= count_r[ADDR_W-1:0];
                    imem_wdata_r <= HALT_WORD;
                    count_r      <= count_inc_s;
                    state_r      <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    done_r     <= 1'b1;
                    busy_r     <= 1'b0;
                    in_ready_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                ST_ERR: begin
                    if (start) begin
                        state_r    <= ST_LOAD;
                        err_r      <= 1'b0;
                        count_r    <= {(ADDR_W+1){1'b0}};
                        in_ready_r <= 1'b1;
                    end else begin
                        in_ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign count      = count_r;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Scoreboard bench for instr_stream_encoder: directed vectors plus random programs
// checked against a field-level reference encoder.
module tb_instr_stream_encoder;

    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, in_last;
    logic [3:0]    in_op;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic [19:0]   in_imm;
    logic          in_ready, imem_we, busy, done, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   bad    = 0;
    int   cyc    = 0;
    int   mcount = 0;

    instr_stream_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference encoder: format class, opcode and funct3 from the ISA table, fields by arithmetic.
    function automatic logic [31:0] ref_enc(input int op, input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic [19:0] imm);
        logic [31:0] w, opc, f3, im;
        int kind; // 0=R 1=I 2=S 3=B 4=U
        w = 32'd0; opc = 32'd0; f3 = 32'd0; kind = 0; im = 32'(imm);
        case (op)
            0:  begin kind = 0; opc = 32'h73; f3 = 32'd0; end
            1:  begin kind = 0; opc = 32'h73; f3 = 32'd0; w = 32'h4000_0000; end
            2:  begin kind = 0; opc = 32'h73; f3 = 32'd1; end
            3:  begin kind = 0; opc = 32'h73; f3 = 32'd2; end
            4:  begin kind = 0; opc = 32'h73; f3 = 32'd4; end
            5:  begin kind = 0; opc = 32'h73; f3 = 32'd5; end
            6:  begin kind = 0; opc = 32'h73; f3 = 32'd6; end
            7:  begin kind = 0; opc = 32'h73; f3 = 32'd7; end
            8:  begin kind = 3; opc = 32'h6B; f3 = 32'd0; end
            9:  begin kind = 3; opc = 32'h6B; f3 = 32'd1; end
            10: begin kind = 2; opc = 32'h63; f3 = 32'd2; end
            11: begin kind = 1; opc = 32'h43; f3 = 32'd2; end
            12: begin kind = 4; opc = 32'h30; f3 = 32'd0; end
            13: begin kind = 1; opc = 32'h1F; f3 = 32'd0; end
            14: begin kind = 1; opc = 32'h1F; f3 = 32'd1; end
            default: begin kind = 1; opc = 32'h1F; f3 = 32'd2; end
        endcase
        w = w | opc | (f3 * 32'd4096);
        if (kind == 0 || kind == 1 || kind == 4) w = w | (32'(rd) << 7);
        if (kind != 4) w = w | (32'(rs1) << 15);
        if (kind == 0 || kind == 2 || kind == 3) w = w | (32'(rs2) << 20);
        case (kind)
            1: w = w | ((im % 32'd4096) << 20);
            2: w = w | (((im / 32'd32) % 32'd128) << 25) | ((im % 32'd32) << 7);
            3: w = w | (((im / 32'd4096) % 32'd2) << 31) | (((im / 32'd32) % 32'd64) << 25)
                     | (((im / 32'd2) % 32'd16) << 8) | (((im / 32'd2048) % 32'd2) << 7);
            4: w = w | (im << 12);
            default: w = w;
        endcase
        return w;
    endfunction

    // Monitor: every write strobe must match the oldest expected write, in the expected cycle.
    always @(negedge clk) begin
        if (imem_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_write actual addr=%0d data=%h required=no write", imem_addr, imem_wdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e.addr));
                chk("wr_data", imem_wdata, e.data);
                chk("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mcount = 0;
    endtask

    task automatic send_beat(input string tag, input logic [3:0] op, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [19:0] imm,
                             input logic last, input logic [31:0] exp_word, input bit exp_acc,
                             input int budget);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1; in_last = last; in_op = op;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back('{addr: mcount, data: exp_word, cyc: cyc + 1});
                mcount++;
                acc = 1'b1;
            end
            @(posedge clk); #1;
            if (acc) break;
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk({tag, "_accept"}, 32'(acc), 32'(exp_acc));
    endtask

    task automatic send_rand(input string tag, input logic last);
        logic [3:0] op; logic [4:0] rd, rs1, rs2; logic [19:0] imm;
        op = 4'($urandom); rd = 5'($urandom); rs1 = 5'($urandom);
        rs2 = 5'($urandom); imm = 20'($urandom);
        send_beat(tag, op, rd, rs1, rs2, imm, last, ref_enc(int'(op), rd, rs1, rs2, imm), 1'b1, 20);
    endtask

    // Called right after the last beat is accepted: expects optional halt write, then done.
    task automatic finish_prog(input string tag);
        int lat, exp_lat;
        lat = 0;
        exp_lat = 2;
`ifdef HALT_PAD_EN
        if (mcount < DEPTH) begin
            exp_q.push_back('{addr: mcount, data: 32'h0000_006B, cyc: cyc + 1});
            mcount++;
            exp_lat = 3;
        end
`endif
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_done_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_count"}, 32'(count), 32'(mcount));
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_op = 4'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 20'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        @(posedge clk); #1;
        rst = 1'b0;

        // ADD x3,x1,x2 as a one-op program.
        do_start();
        send_beat("add", 4'd0, 5'd3, 5'd1, 5'd2, 20'd0, 1'b1, 32'h0020_81F3, 1'b1, 20);
        finish_prog("add");

        // SUB then ADDI with all-ones 12-bit immediate.
        do_start();
        send_beat("sub", 4'd1, 5'd3, 5'd1, 5'd2, 20'd0, 1'b0, 32'h4020_81F3, 1'b1, 20);
        send_beat("addi", 4'd13, 5'd5, 5'd0, 5'd0, 20'h00FFF, 1'b1, 32'hFFF0_029F, 1'b1, 20);
        finish_prog("sub_addi");

        // LUI then SW.
        do_start();
        send_beat("lui", 4'd12, 5'd7, 5'd0, 5'd0, 20'h12345, 1'b0, 32'h1234_53B0, 1'b1, 20);
        send_beat("sw", 4'd10, 5'd0, 5'd1, 5'd2, 20'd8, 1'b1, 32'h0020_A463, 1'b1, 20);
        finish_prog("lui_sw");

        // start while loading must not restart the address sequence.
        do_start();
        send_rand("ign0", 1'b0);
        send_rand("ign1", 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send_rand("ign2", 1'b1);
        finish_prog("start_ignored");

        // Overflow: DEPTH non-last beats fill memory and trap in ERR.
        do_start();
        for (int i = 0; i < DEPTH; i++) send_rand("ovf", 1'b0);
        @(negedge clk);
        chk("ovf_err", 32'(err), 32'd1);
        chk("ovf_in_ready", 32'(in_ready), 32'd0);
        chk("ovf_busy", 32'(busy), 32'd1);
        chk("ovf_count", 32'(count), 32'(DEPTH));
        @(posedge clk); #1;
        send_beat("ovf_extra", 4'd0, 5'd1, 5'd1, 5'd1, 20'd0, 1'b0, 32'd0, 1'b0, 4);
        chk("ovf_err_sticky", 32'(err), 32'd1);
        do_start();
        @(negedge clk);
        chk("restart_err", 32'(err), 32'd0);
        chk("restart_in_ready", 32'(in_ready), 32'd1);
        chk("restart_count", 32'(count), 32'd0);
        @(posedge clk); #1;
        send_rand("restart", 1'b1);
        finish_prog("restart");

        // Random programs of length 1..DEPTH with idle gaps between beats.
        for (int p = 0; p < 25; p++) begin
            int len;
            len = int'($urandom_range(1, DEPTH));
            do_start();
            for (int b = 0; b < len; b++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                send_rand("rnd", (b == len - 1));
            end
            finish_prog("rnd");
        end

        // Reset the cycle after an accept mid-load.
        do_start();
        send_rand("rst_mid0", 1'b0);
        send_rand("rst_mid1", 1'b0);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_no_we", 32'(imem_we), 32'd0);
        end
        chk_reset_vals("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
